// File: rtl/timer_counter.sv
// timer_counter: memory-mapped 32-bit down-counting timer with one interrupt line.
// Register map (byte offsets from BASE_ADDR):
//   +0 CTRL   rw  [0]EN [2:1]MODE [3]IM (+ [6:4]PSC with TC_PRESCALE_EN)
//   +4 PRESET rw  reload value
//   +8 COUNT  ro  current count
// Optional feature macro: TC_PRESCALE_EN (adds the CTRL[6:4] count prescaler).
// Bus protocol: a write is accepted at the rising clk edge of any cycle in which
// we=1 and addr selects a writable register. There is no back-pressure and no
// wait state. Reads are combinational on addr.
module timer_counter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_e;

`ifdef TC_PRESCALE_EN
  localparam logic [31:0] CTRL_MASK = 32'h0000_007F;
`else
  localparam logic [31:0] CTRL_MASK = 32'h0000_000F;
`endif

  state_e      state_q, state_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic        hit;
  logic        wr_ctrl;
  logic        wr_preset;
  logic [31:0] ctrl_eff;
  logic        en_eff;
  logic        auto_reload;
  logic        tick;

  // Address decode: only the three aligned register slots respond.
  assign hit = (addr[31:4] == BASE_ADDR[31:4]) &&
               ((addr[3:0] == 4'h0) || (addr[3:0] == 4'h4) || (addr[3:0] == 4'h8));
  assign wr_ctrl   = we && hit && (addr[3:0] == 4'h0);
  assign wr_preset = we && hit && (addr[3:0] == 4'h4);

  // The FSM looks at the control word as it will be after this edge, so a CPU
  // write to CTRL takes effect on the counter at the same edge it lands.
  assign ctrl_eff    = wr_ctrl ? (din & CTRL_MASK) : ctrl_q;
  assign en_eff      = ctrl_eff[0];
  assign auto_reload = (ctrl_eff[2:1] == 2'b01);  // MODE 2/3 reserved, act as one-shot

`ifdef TC_PRESCALE_EN
  logic [7:0] psc_cnt_q, psc_cnt_d;
  logic [7:0] psc_limit;

  assign psc_limit = (8'd1 << ctrl_q[6:4]) - 8'd1;
  assign tick      = (psc_cnt_q == psc_limit);

  // Prescale counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) psc_cnt_q <= '0;
    else        psc_cnt_q <= psc_cnt_d;
  end

  // Prescaler advances only while counting; it restarts on every tick and outside CNT.
  always_comb begin
    psc_cnt_d = '0;
    if ((state_q == S_CNT) && en_eff && !tick) psc_cnt_d = psc_cnt_q + 8'd1;
  end
`else
  assign tick = 1'b1;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (en_eff) state_d = S_LOAD;
      S_LOAD: state_d = en_eff ? S_CNT : S_IDLE;
      S_CNT: begin
        if (!en_eff)                            state_d = S_IDLE;
        else if (tick && (count_q <= 32'd1))    state_d = S_INT;
      end
      S_INT: begin
        if (en_eff && auto_reload) state_d = S_LOAD;
        else                       state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output logic: register updates driven by state and bus writes.
  always_comb begin
    ctrl_d     = ctrl_eff;
    preset_d   = wr_preset ? din : preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    case (state_q)
      S_LOAD: if (en_eff) count_d = preset_q;
      S_CNT: begin
        if (en_eff && tick) begin
          if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
          end else begin
            count_d    = '0;
            irq_flag_d = 1'b1;
          end
        end
      end
      S_INT: begin
        // One-shot disarms itself unless the CPU is writing CTRL this edge.
        if (auto_reload)   irq_flag_d = 1'b0;
        else if (!wr_ctrl) ctrl_d[0]  = 1'b0;
      end
      default: ;
    endcase
    // Any CTRL write acknowledges the interrupt, overriding a same-edge set.
    if (wr_ctrl) irq_flag_d = 1'b0;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  // Read mux: unmapped or misaligned addresses return zero.
  always_comb begin
    dout = '0;
    if (hit) begin
      case (addr[3:0])
        4'h0:    dout = ctrl_q;
        4'h4:    dout = preset_q;
        4'h8:    dout = count_q;
        default: dout = '0;
      endcase
    end
  end

  assign irq = irq_flag_q & ctrl_q[3];

endmodule
